asu_riscv_mult_ctrl: RTL

// - Issue/sequencing stage directly upstream of the 2-cycle MAC multiplier; consumes MUL-class ops from EX.
// - Decodes funct3 into multiplier operator/sign mode and registers operands.
// - Holds the multiplier inputs stable for its 1 (MUL) or 2 (MULH/MULHSU/MULHU) cycles.
// - Captures the result and returns it to writeback over a valid/ready channel tagged with rd.

---
 rtl/asu_riscv_pkg.sv | 31 +++
 rtl/asu_riscv_mult_decode.sv | 41 ++++
 rtl/asu_riscv_mult_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/asu_riscv_pkg.sv
// Shared encodings for the MUL-class issue stage: funct3 values, multiplier
// operator and signed-mode codes, and the sequencing FSM state type.
package asu_riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W_DEF = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Multiplier operator: 00 selects the low word, any other code the high word.
  localparam logic [1:0] MOP_LOW    = 2'b00;
  localparam logic [1:0] MOP_MULH   = 2'b01;
  localparam logic [1:0] MOP_MULHSU = 2'b10;
  localparam logic [1:0] MOP_MULHU  = 2'b11;

  // Signed mode: bit0 = operand a signed, bit1 = operand b signed.
  localparam logic [1:0] SMODE_UU = 2'b00;
  localparam logic [1:0] SMODE_SU = 2'b01;
  localparam logic [1:0] SMODE_SS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_EXEC_HI = 2'd2,
    ST_RESP    = 2'd3
  } mult_state_e;

endpackage

// File: rtl/asu_riscv_mult_decode.sv
// Combinational funct3 decode into multiplier operator, signed mode and a
// flag marking the two-cycle high-word operations.
module asu_riscv_mult_decode
  import asu_riscv_pkg::*;
(
  input  logic [2:0] funct3,
  output logic [1:0] mul_op,
  output logic [1:0] sign_mode,
  output logic       is_high
);

  // funct3[2] is never routed here; any such code falls back to plain MUL.
  always_comb begin
    mul_op    = MOP_LOW;
    sign_mode = SMODE_UU;
    is_high   = 1'b0;
    case (funct3)
      F3_MULH: begin
        mul_op    = MOP_MULH;
        sign_mode = SMODE_SS;
        is_high   = 1'b1;
      end
      F3_MULHSU: begin
        mul_op    = MOP_MULHSU;
        sign_mode = SMODE_SU;
        is_high   = 1'b1;
      end
      F3_MULHU: begin
        mul_op    = MOP_MULHU;
        sign_mode = SMODE_UU;
        is_high   = 1'b1;
      end
      default: begin
        mul_op    = MOP_LOW;
        sign_mode = SMODE_UU;
        is_high   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/asu_riscv_mult_ctrl.sv
// Issue/sequencing stage in front of the 2-cycle MAC multiplier. Registers a
// decoded MUL-class op, holds the multiplier inputs for 1 or 2 cycles,
// captures the product and hands it to writeback over valid/ready.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a new op; multiplier operator forced low, operands 0
// ST_EXEC    | first multiplier cycle; MUL result captured here
// ST_EXEC_HI | second cycle of a high-word op; operands held, result captured
// ST_RESP    | result presented to writeback until rsp_ready_i
module asu_riscv_mult_ctrl
  import asu_riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [RD_W-1:0] req_rd_i,
  input  logic [XLEN-1:0] req_op_a_i,
  input  logic [XLEN-1:0] req_op_b_i,
  output logic [1:0]      mul_operator_o,
  output logic [1:0]      mul_signed_mode_o,
  output logic [XLEN-1:0] mul_op_a_o,
  output logic [XLEN-1:0] mul_op_b_o,
  input  logic [XLEN-1:0] mul_result_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [RD_W-1:0] rsp_rd_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o
);

  mult_state_e     state_q, state_d;
  logic [1:0]      dec_mul_op, dec_sign_mode;
  logic            dec_is_high;
  logic [1:0]      mul_op_q, sign_mode_q;
  logic            is_high_q;
  logic [XLEN-1:0] op_a_q, op_b_q, result_q;
  logic [RD_W-1:0] rd_q;
  logic            accept, capture, in_exec;

  asu_riscv_mult_decode u_decode (
    .funct3    (req_funct3_i),
    .mul_op    (dec_mul_op),
    .sign_mode (dec_sign_mode),
    .is_high   (dec_is_high)
  );

  // Ready is held low while in reset so no op is handed to a block in reset.
  assign req_ready_o = nrst & ((state_q == ST_IDLE) |
                               ((state_q == ST_RESP) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o & ~flush_i;
  assign in_exec     = (state_q == ST_EXEC) | (state_q == ST_EXEC_HI);
  assign capture     = ~flush_i & (((state_q == ST_EXEC) & ~is_high_q) |
                                   (state_q == ST_EXEC_HI));

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_EXEC;
      ST_EXEC:    state_d = is_high_q ? ST_EXEC_HI : ST_RESP;
      ST_EXEC_HI: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready_i) state_d = accept ? ST_EXEC : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Decoded op, operands and tag are latched on acceptance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mul_op_q    <= MOP_LOW;
      sign_mode_q <= SMODE_UU;
      is_high_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rd_q        <= '0;
    end else if (accept) begin
      mul_op_q    <= dec_mul_op;
      sign_mode_q <= dec_sign_mode;
      is_high_q   <= dec_is_high;
      op_a_q      <= req_op_a_i;
      op_b_q      <= req_op_b_i;
      rd_q        <= req_rd_i;
    end
  end

  // Product capture in the final multiplier cycle; a flushed op is not captured.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        result_q <= '0;
    else if (capture) result_q <= mul_result_i;
  end

  // Operator low outside the execute states keeps the multiplier in state 0.
  always_comb begin
    mul_operator_o    = in_exec ? mul_op_q    : MOP_LOW;
    mul_signed_mode_o = in_exec ? sign_mode_q : SMODE_UU;
    mul_op_a_o        = (state_q == ST_IDLE) ? '0 : op_a_q;
    mul_op_b_o        = (state_q == ST_IDLE) ? '0 : op_b_q;
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rd_o    = rd_q;
  assign rsp_data_o  = result_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
